// File: rtl/uart_bridge_pkg.sv
// Shared constants and helpers for the UART <-> datapath FIFO bridge.
package uart_bridge_pkg;

    localparam int unsigned UART_BYTE_W   = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned clog2p1(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy count and a
// sticky overflow flag. Push/pop arrive already qualified by the parent;
// drop marks a rejected write so the flag can be set here.
module sync_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = UART_BYTE_W
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        drop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic                        full,
    output logic [clog2p1(DEPTH)-1:0]   count,
    output logic                        overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = clog2p1(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    // Head is shown only while occupied so an empty FIFO presents zero.
    assign dout     = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer, occupancy and sticky flag update; flush overrides any traffic.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Bridge between the byte-serial UART and the datapath's MMIO strobes:
// an RX FIFO (UART -> datapath) and a TX FIFO (datapath -> UART).
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = UART_BYTE_W
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            rx_data,
    input  logic                        rx_valid,
    output logic [WIDTH-1:0]            tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [WIDTH-1:0]            DataOut,
    output logic                        DataOutValid,
    input  logic                        DataOutReady,
    input  logic [WIDTH-1:0]            DataIn,
    input  logic                        DataInValid,
    output logic                        DataInReady,
    output logic [clog2p1(DEPTH)-1:0]   rx_count,
    output logic [clog2p1(DEPTH)-1:0]   tx_count,
    output logic                        rx_overflow,
    output logic                        tx_overflow
);

    logic rx_empty, rx_full, rx_push, rx_pop, rx_drop;
    logic tx_empty, tx_full, tx_push, tx_pop, tx_drop;

    // A write into a full FIFO is still accepted when the head leaves in the
    // same cycle; otherwise it is dropped and flagged.
    assign rx_pop  = DataOutReady && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign rx_drop = rx_valid && rx_full && !rx_pop;

    assign tx_pop  = tx_ready && !tx_empty;
    assign tx_push = DataInValid && (!tx_full || tx_pop);
    assign tx_drop = DataInValid && tx_full && !tx_pop;

    // Status depends only on registered occupancy.
    assign DataOutValid = !rx_empty;
    assign tx_valid     = !tx_empty;
    assign DataInReady  = !tx_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_rx_fifo (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (rx_push),
        .pop      (rx_pop),
        .drop     (rx_drop),
        .din      (rx_data),
        .dout     (DataOut),
        .empty    (rx_empty),
        .full     (rx_full),
        .count    (rx_count),
        .overflow (rx_overflow)
    );

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_tx_fifo (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (tx_push),
        .pop      (tx_pop),
        .drop     (tx_drop),
        .din      (DataIn),
        .dout     (tx_data),
        .empty    (tx_empty),
        .full     (tx_full),
        .count    (tx_count),
        .overflow (tx_overflow)
    );

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences.
module tb_uart_fifo_bridge;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       flush;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic [3:0] rx_count;
    logic [3:0] tx_count;
    logic       rx_overflow;
    logic       tx_overflow;

    int n_vec = 0;
    int n_err = 0;

    uart_fifo_bridge #(
        .DEPTH (8),
        .WIDTH (8)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .flush        (flush),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .DataOut      (DataOut),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady),
        .DataIn       (DataIn),
        .DataInValid  (DataInValid),
        .DataInReady  (DataInReady),
        .rx_count     (rx_count),
        .tx_count     (tx_count),
        .rx_overflow  (rx_overflow),
        .tx_overflow  (tx_overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       dor;
        logic       div;
        logic [7:0] di;
        logic       txr;
        logic       e_dov;
        logic [7:0] e_do;
        logic [3:0] e_rxc;
        logic       e_txv;
        logic [7:0] e_txd;
        logic [3:0] e_txc;
        logic       e_dir;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        DataOutReady = 1'b0;
        DataInValid  = 1'b0;
        DataIn       = 8'h00;
        tx_ready     = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_empty_state(input string tag);
        chk({tag, ".DataOutValid"}, 32'(DataOutValid), 32'd0);
        chk({tag, ".DataOut"},      32'(DataOut),      32'h00);
        chk({tag, ".rx_count"},     32'(rx_count),     32'd0);
        chk({tag, ".tx_valid"},     32'(tx_valid),     32'd0);
        chk({tag, ".tx_data"},      32'(tx_data),      32'h00);
        chk({tag, ".tx_count"},     32'(tx_count),     32'd0);
        chk({tag, ".DataInReady"},  32'(DataInReady),  32'd1);
        chk({tag, ".rx_overflow"},  32'(rx_overflow),  32'd0);
        chk({tag, ".tx_overflow"},  32'(tx_overflow),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            rxv rxd   dor div di    txr | dov do    rxc txv txd   txc dir
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 4'd1, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 4'd2, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 4'd1, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'h10, 4'd1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 8'h11, 4'd1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 8'h20, 4'd1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[11] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 4'd1, 1'b0, 8'h00, 4'd0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b1};

        idle();
        reset_n = 1'b0;
        #2;
        chk_empty_state("reset");
        #10;
        reset_n = 1'b1;
        step();

        // Single-cycle behaviour from the vector table.
        for (int i = 0; i < 13; i++) begin
            rx_valid     = tbl[i].rxv;
            rx_data      = tbl[i].rxd;
            DataOutReady = tbl[i].dor;
            DataInValid  = tbl[i].div;
            DataIn       = tbl[i].di;
            tx_ready     = tbl[i].txr;
            step();
            chk($sformatf("v%0d.DataOutValid", i), 32'(DataOutValid), 32'(tbl[i].e_dov));
            chk($sformatf("v%0d.DataOut", i),      32'(DataOut),      32'(tbl[i].e_do));
            chk($sformatf("v%0d.rx_count", i),     32'(rx_count),     32'(tbl[i].e_rxc));
            chk($sformatf("v%0d.tx_valid", i),     32'(tx_valid),     32'(tbl[i].e_txv));
            chk($sformatf("v%0d.tx_data", i),      32'(tx_data),      32'(tbl[i].e_txd));
            chk($sformatf("v%0d.tx_count", i),     32'(tx_count),     32'(tbl[i].e_txc));
            chk($sformatf("v%0d.DataInReady", i),  32'(DataInReady),  32'(tbl[i].e_dir));
            chk($sformatf("v%0d.rx_overflow", i),  32'(rx_overflow),  32'd0);
            chk($sformatf("v%0d.tx_overflow", i),  32'(tx_overflow),  32'd0);
        end
        idle();

        // RX fill to full, ninth byte dropped, drain in order; flag stays set.
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            step();
        end
        rx_data = 8'hFF;
        step();
        idle();
        chk("rxfull.count", 32'(rx_count), 32'd8);
        chk("rxfull.overflow", 32'(rx_overflow), 32'd1);
        chk("rxfull.DataInReady", 32'(DataInReady), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rxdrain%0d.DataOut", i), 32'(DataOut), 32'(i));
            DataOutReady = 1'b1;
            step();
        end
        idle();
        chk("rxdrain.valid", 32'(DataOutValid), 32'd0);
        chk("rxdrain.count", 32'(rx_count), 32'd0);
        chk("rxdrain.sticky", 32'(rx_overflow), 32'd1);

        // TX fill to full, 0xAA dropped, drain at one byte per cycle.
        for (int i = 0; i < 8; i++) begin
            DataInValid = 1'b1;
            DataIn      = 8'hC0 + 8'(i);
            step();
        end
        chk("txfull.DataInReady", 32'(DataInReady), 32'd0);
        chk("txfull.count", 32'(tx_count), 32'd8);
        DataIn = 8'hAA;
        step();
        idle();
        chk("txfull.overflow", 32'(tx_overflow), 32'd1);
        chk("txfull.count9", 32'(tx_count), 32'd8);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("txdrain%0d.tx_data", i), 32'(tx_data), 32'(8'hC0 + 8'(i)));
            chk($sformatf("txdrain%0d.tx_valid", i), 32'(tx_valid), 32'd1);
            step();
        end
        idle();
        chk("txdrain.valid", 32'(tx_valid), 32'd0);
        chk("txdrain.count", 32'(tx_count), 32'd0);
        chk("txdrain.sticky", 32'(tx_overflow), 32'd1);

        // Flush with five bytes in each FIFO, flags set, and concurrent traffic.
        for (int i = 0; i < 5; i++) begin
            rx_valid    = 1'b1;
            rx_data     = 8'h50 + 8'(i);
            DataInValid = 1'b1;
            DataIn      = 8'h70 + 8'(i);
            step();
        end
        chk("preflush.rx_count", 32'(rx_count), 32'd5);
        chk("preflush.tx_count", 32'(tx_count), 32'd5);
        flush        = 1'b1;
        DataOutReady = 1'b1;
        tx_ready     = 1'b1;
        step();
        idle();
        chk_empty_state("flush");

        // Full RX with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h60 + 8'(i);
            step();
        end
        chk("fullpp.head0", 32'(DataOut), 32'h60);
        rx_data      = 8'h55;
        DataOutReady = 1'b1;
        step();
        idle();
        chk("fullpp.count", 32'(rx_count), 32'd8);
        chk("fullpp.head1", 32'(DataOut), 32'h61);
        chk("fullpp.overflow", 32'(rx_overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpp.drain%0d", i), 32'(DataOut),
                (i == 7) ? 32'h55 : 32'(8'h61 + 8'(i)));
            DataOutReady = 1'b1;
            step();
        end
        idle();
        chk("fullpp.empty", 32'(rx_count), 32'd0);

        // Pointer wrap: one byte in flight, push and pop together 19 times.
        rx_valid = 1'b1;
        rx_data  = 8'h80;
        step();
        for (int k = 1; k < 20; k++) begin
            chk($sformatf("wrap%0d.head", k), 32'(DataOut), 32'(8'h80 + 8'(k - 1)));
            rx_valid     = 1'b1;
            rx_data      = 8'h80 + 8'(k);
            DataOutReady = 1'b1;
            step();
            chk($sformatf("wrap%0d.count", k), 32'(rx_count), 32'd1);
        end
        idle();
        chk("wrap.last", 32'(DataOut), 32'h93);
        DataOutReady = 1'b1;
        step();
        idle();
        chk("wrap.empty", 32'(DataOutValid), 32'd0);

        // Asynchronous reset mid-stream clears outputs before the next edge.
        for (int i = 0; i < 3; i++) begin
            rx_valid    = 1'b1;
            rx_data     = 8'hA0 + 8'(i);
            DataInValid = 1'b1;
            DataIn      = 8'hB0 + 8'(i);
            step();
        end
        chk("prereset.rx_count", 32'(rx_count), 32'd3);
        chk("prereset.tx_count", 32'(tx_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_empty_state("async_reset");
        idle();
        #3;
        reset_n = 1'b1;
        step();
        chk_empty_state("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
